// File: rtl/reg_file_scoreboard_if.sv
// Bus bundle for reg_file_scoreboard: write, reserve and two read ports.
// The master drives requests. The slave (the register file) drives read data and scoreboard status.
interface reg_file_scoreboard_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                  Write_Enable;
   logic [ADDR_WIDTH-1:0] Reg_Write;
   logic [DATA_WIDTH-1:0] Write_Data;
   logic [ADDR_WIDTH-1:0] Reg_Read_A;
   logic [ADDR_WIDTH-1:0] Reg_Read_B;
   logic [DATA_WIDTH-1:0] Reg_A;
   logic [DATA_WIDTH-1:0] Reg_B;
   logic                  Reserve_Enable;
   logic [ADDR_WIDTH-1:0] Reg_Reserve;
   logic                  Busy_A;
   logic                  Busy_B;
   logic                  Hazard;
   logic [ADDR_WIDTH:0]   Pending_Count;

   modport master (
      output Write_Enable, Reg_Write, Write_Data, Reg_Read_A, Reg_Read_B,
             Reserve_Enable, Reg_Reserve,
      input  Reg_A, Reg_B, Busy_A, Busy_B, Hazard, Pending_Count
   );

   modport slave (
      input  Write_Enable, Reg_Write, Write_Data, Reg_Read_A, Reg_Read_B,
             Reserve_Enable, Reg_Reserve,
      output Reg_A, Reg_B, Busy_A, Busy_B, Hazard, Pending_Count
   );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Two-read/one-write register file with per-register busy scoreboard and pending counter.
// Define REG_FILE_ZERO_REG_EN to make register 0 read as zero and never become busy.
module reg_file_scoreboard #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input logic                  Clk,
   input logic                  Reset,
   reg_file_scoreboard_if.slave bus
);
   localparam int NREG = 2 ** ADDR_WIDTH;
   localparam int CW   = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] regs_q [NREG];
   logic [DATA_WIDTH-1:0] regs_d [NREG];
   logic [NREG-1:0]       busy_q, busy_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  wr_ok, rs_ok, inc, dec;
   logic                  byp_a, byp_b, busy_a, busy_b;

   always_comb begin
      wr_ok = bus.Write_Enable;
      rs_ok = bus.Reserve_Enable;
`ifdef REG_FILE_ZERO_REG_EN
      if (bus.Reg_Write == '0) wr_ok = 1'b0;
      if (bus.Reg_Reserve == '0) rs_ok = 1'b0;
`endif
   end

   // Reserve is applied after the write so that a same-address reserve wins.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_ok) begin
         regs_d[bus.Reg_Write] = bus.Write_Data;
         busy_d[bus.Reg_Write] = 1'b0;
      end
      if (rs_ok) busy_d[bus.Reg_Reserve] = 1'b1;
   end

   // The counter follows net busy transitions: a set that was already set does not count.
   // A clear is cancelled by a reserve to the same address on the same edge.
   always_comb begin
      inc     = rs_ok && !busy_q[bus.Reg_Reserve];
      dec     = wr_ok && busy_q[bus.Reg_Write] &&
                !(rs_ok && (bus.Reg_Reserve == bus.Reg_Write));
      count_d = count_q + {{ADDR_WIDTH{1'b0}}, inc} - {{ADDR_WIDTH{1'b0}}, dec};
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         regs_q  <= '{default: '0};
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         regs_q  <= regs_d;
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   // The read bypass is ungated by reset, so it stays active while Reset is high.
   always_comb begin
      byp_a             = wr_ok && (bus.Reg_Write == bus.Reg_Read_A);
      byp_b             = wr_ok && (bus.Reg_Write == bus.Reg_Read_B);
      busy_a            = busy_q[bus.Reg_Read_A] && !byp_a;
      busy_b            = busy_q[bus.Reg_Read_B] && !byp_b;
      bus.Reg_A         = byp_a ? bus.Write_Data : regs_q[bus.Reg_Read_A];
      bus.Reg_B         = byp_b ? bus.Write_Data : regs_q[bus.Reg_Read_B];
      bus.Busy_A        = busy_a;
      bus.Busy_B        = busy_b;
      bus.Hazard        = busy_a || busy_b;
      bus.Pending_Count = count_q;
   end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed and random checks of reg_file_scoreboard against an array-based reference model.
// Build with REG_FILE_ZERO_REG_EN defined to exercise the hardwired-zero register.
module tb_reg_file_scoreboard;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NR = 16;

   logic Clk = 1'b0;
   logic Reset;
   int   tests = 0;
   int   fails = 0;

   logic [DW-1:0] mdl_data [NR];
   bit            mdl_busy [NR];

   reg_file_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   reg_file_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;

   function automatic bit is_zero_reg(input logic [AW-1:0] a);
`ifdef REG_FILE_ZERO_REG_EN
      return a == 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit bypass(input logic [AW-1:0] ra);
      return bus.Write_Enable && bus.Reg_Write == ra && !is_zero_reg(ra);
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] ra);
      if (bypass(ra)) return bus.Write_Data;
      if (is_zero_reg(ra)) return '0;
      return mdl_data[ra];
   endfunction

   function automatic bit exp_busy(input logic [AW-1:0] ra);
      return mdl_busy[ra] && !bypass(ra);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int cnt = 0;
      for (int i = 0; i < NR; i++) cnt += int'(mdl_busy[i]);
      chk({tag, "/Reg_A"}, 32'(bus.Reg_A), 32'(exp_data(bus.Reg_Read_A)));
      chk({tag, "/Reg_B"}, 32'(bus.Reg_B), 32'(exp_data(bus.Reg_Read_B)));
      chk({tag, "/Busy_A"}, 32'(bus.Busy_A), 32'(exp_busy(bus.Reg_Read_A)));
      chk({tag, "/Busy_B"}, 32'(bus.Busy_B), 32'(exp_busy(bus.Reg_Read_B)));
      chk({tag, "/Hazard"}, 32'(bus.Hazard),
          32'(exp_busy(bus.Reg_Read_A) || exp_busy(bus.Reg_Read_B)));
      chk({tag, "/Count"}, 32'(bus.Pending_Count), 32'(cnt));
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < NR; i++) begin
         mdl_data[i] = '0;
         mdl_busy[i] = 1'b0;
      end
   endtask

   // Check the settled outputs, take one edge, update the model, and return at the next negedge.
   task automatic step(input string tag);
      #1 check_all(tag);
      @(posedge Clk);
      if (!Reset) begin
         if (bus.Write_Enable && !is_zero_reg(bus.Reg_Write)) begin
            mdl_data[bus.Reg_Write] = bus.Write_Data;
            mdl_busy[bus.Reg_Write] = 1'b0;
         end
         if (bus.Reserve_Enable && !is_zero_reg(bus.Reg_Reserve))
            mdl_busy[bus.Reg_Reserve] = 1'b1;
      end
      @(negedge Clk);
   endtask

   task automatic drive(input bit we, input int wa, input int wd,
                        input bit re, input int rr, input int ra, input int rb);
      bus.Write_Enable   = we;
      bus.Reg_Write      = AW'(wa);
      bus.Write_Data     = DW'(wd);
      bus.Reserve_Enable = re;
      bus.Reg_Reserve    = AW'(rr);
      bus.Reg_Read_A     = AW'(ra);
      bus.Reg_Read_B     = AW'(rb);
   endtask

   initial begin
      Reset = 1'b1;
      mdl_clear();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      @(negedge Clk);

      for (int a = 0; a < NR; a++) begin
         drive(0, 0, 0, 0, 0, a, NR - 1 - a);
         #1 check_all("reset_read");
      end

      // Writes and reserves are ignored while Reset is high, but the bypass is still visible.
      drive(1, 5, 'hABCD, 1, 5, 5, 6);
      step("reset_bypass");
      drive(0, 0, 0, 0, 0, 5, 6);
      #1 check_all("reset_ignored");

      // The first edge after release is processed normally.
      Reset = 1'b0;
      drive(1, 2, 'h5A5A, 1, 9, 2, 9);
      step("first_edge");
      drive(0, 0, 0, 0, 0, 2, 9);
      step("first_edge_after");

      drive(1, 5, 'hBEEF, 0, 0, 5, 0);
      step("bypass_5");
      drive(0, 0, 0, 0, 0, 5, 0);
      step("read_5");
      chk("read_5_const", 32'(bus.Reg_A), 32'hBEEF);

      drive(0, 0, 0, 1, 3, 0, 0);
      step("rsv_3");
      drive(0, 0, 0, 1, 7, 0, 0);
      step("rsv_7");
      drive(0, 0, 0, 0, 0, 3, 7);
      step("busy_7");
      drive(1, 7, 'h1234, 0, 0, 3, 7);
      #1 chk("wr7_busy_b", 32'(bus.Busy_B), 32'd0);
      step("wr_7");
      drive(0, 0, 0, 0, 0, 3, 7);
      step("after_wr_7");

      drive(1, 4, 'h00AA, 1, 4, 4, 4);
      step("rsv_wr_4");
      drive(0, 0, 0, 0, 0, 4, 4);
      #1 chk("rsv_wr_4_busy", 32'(bus.Busy_A), 32'd1);
      step("after_rsv_wr_4");
      drive(0, 0, 0, 1, 4, 4, 0);
      step("rsv_4_again");
      drive(0, 0, 0, 0, 0, 4, 0);
      step("after_rsv_4_again");

      // Address 0: hardwired zero with the macro, an ordinary register otherwise.
      drive(1, 0, 'hFFFF, 1, 0, 0, 0);
      step("reg0_wr_rsv");
      drive(0, 0, 0, 0, 0, 0, 0);
      step("reg0_after");

      for (int n = 0; n < 400; n++) begin
         drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, NR - 1)),
               int'($urandom_range(0, 16'hFFFF)), bit'($urandom_range(0, 1)),
               int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
               int'($urandom_range(0, NR - 1)));
         step("rnd");
      end

      for (int a = 0; a < NR; a++) begin
         drive(0, 0, 0, 1, a, a, 0);
         step("rsv_all");
      end
      drive(0, 0, 0, 1, 9, 9, 10);
      step("rsv_saturated");

      // A short reset pulse between edges clears everything at once.
      drive(0, 0, 0, 0, 0, 9, 10);
      #2 Reset = 1'b1;
      mdl_clear();
      #1 check_all("mid_reset");
      #1 Reset = 1'b0;
      step("after_mid_reset");
      drive(1, 11, 'h0F0F, 1, 12, 11, 12);
      step("post_reset_op");
      drive(0, 0, 0, 0, 0, 11, 12);
      step("post_reset_read");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
